imem_pipe: RTL and testbench

Parametrised synchronous instruction memory for the RISC-V core, replacing the combinational word-array fetch memory. It has three ports:
- a fetch port with a valid/ready handshake and configurable read latency, used by the PC/IF stage;
- a byte-enabled load port, used by the testbench or boot loader;
- a hardware bulk-clear sequencer.

Out-of-range and misaligned fetches return a NOP with a fault flag instead of aliasing.

---
 rtl/imem_pipe.sv | 129 ++++++++++++
 tb/tb_imem_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_pipe.sv
// rtl/imem_pipe.sv - synchronous instruction memory with pipelined fetch, byte-enabled load port and bulk clear
module imem_pipe #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    MEM_DEPTH    = 1024,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fetch_req,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic                    fetch_ready,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_fault,
  input  logic                    resp_ready,
  input  logic                    ld_en,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  input  logic [DATA_WIDTH-1:0]   ld_data,
  input  logic [DATA_WIDTH/8-1:0] ld_be,
  input  logic                    clear_start,
  output logic                    busy
);

  localparam int                    IW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int                    NB       = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [IW-1:0]         LAST_IDX = IW'(MEM_DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  logic [IW-1:0]           clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0]   f_idx;
  logic [ADDR_WIDTH-1:0]   l_idx;
  logic                    f_fault;
  logic                    l_hit;
  logic                    advance;
  logic                    accept;
  logic                    ld_unused;

  logic [READ_LATENCY-1:0] pv;
  logic [READ_LATENCY-1:0] pf;
  logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];

  // Word indices are byte address / 4; the load port ignores the low two address bits.
  assign f_idx     = fetch_addr >> 2;
  assign l_idx     = ld_addr >> 2;
  assign f_fault   = (fetch_addr[1:0] != 2'b00) || (f_idx >= DEPTH_A);
  assign l_hit     = ld_en && (l_idx < DEPTH_A);
  assign ld_unused = ^ld_addr[1:0];

  assign advance     = !resp_valid || resp_ready;
  assign fetch_ready = advance && (state == IDLE);
  assign accept      = fetch_req && fetch_ready;

  assign resp_valid = pv[READ_LATENCY-1];
  assign resp_fault = pf[READ_LATENCY-1];
  assign resp_data  = pd[READ_LATENCY-1];

  // Array writes: the clear sequencer zeroes its word, and load-port bytes written later override it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end
    if (l_hit) begin
      for (int b = 0; b < NB; b++) begin
        if (ld_be[b]) begin
          mem[l_idx[IW-1:0]][b*8 +: 8] <= ld_data[b*8 +: 8];
        end
      end
    end
  end

  // Clear sequencer: walks indices 0..MEM_DEPTH-1, one per cycle; busy is registered alongside state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch pipeline: stage 0 reads the array (read-first) or substitutes the NOP, later stages only carry it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv <= '0;
      pf <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pd[i] <= '0;
      end
    end else if (advance) begin
      pv[0] <= accept;
      pf[0] <= f_fault;
      pd[0] <= f_fault ? NOP_WORD : mem[f_idx[IW-1:0]];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pf[i] <= pf[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

endmodule

// File: tb/tb_imem_pipe.sv
// tb/tb_imem_pipe.sv - self-checking bench for imem_pipe at read latencies 1 and 3
module tb_imem_pipe;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, req1, req3, rr1, rr3, ld_en, clr;
  logic [31:0] fa, ld_addr, ld_data;
  logic [3:0]  ld_be;
  logic        fr1, rv1, rf1, busy1, fr3, rv3, rf3, busy3;
  logic [31:0] rd1, rd3;

  imem_pipe #(.MEM_DEPTH(DEPTH), .READ_LATENCY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .fetch_req(req1), .fetch_addr(fa), .fetch_ready(fr1),
    .resp_valid(rv1), .resp_data(rd1), .resp_fault(rf1), .resp_ready(rr1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
    .clear_start(clr), .busy(busy1)
  );

  imem_pipe #(.MEM_DEPTH(DEPTH), .READ_LATENCY(3)) u3 (
    .clk(clk), .reset_n(reset_n), .fetch_req(req3), .fetch_addr(fa), .fetch_ready(fr3),
    .resp_valid(rv3), .resp_data(rd3), .resp_fault(rf3), .resp_ready(rr3),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
    .clear_start(clr), .busy(busy3)
  );

  typedef struct packed { logic [31:0] data; logic fault; } resp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic fault; } vec_t;
  typedef struct packed { logic req; logic [31:0] addr; logic rr; logic v; logic [31:0] d; } seq_t;

  resp_t       q1[$];
  resp_t       q3[$];
  logic [31:0] mem_m [DEPTH];
  int          busy_left;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic resp_t model_fetch(input logic [31:0] a);
    resp_t r;
    if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) begin
      r.data  = NOP;
      r.fault = 1'b1;
    end else begin
      r.data  = mem_m[a >> 2];
      r.fault = 1'b0;
    end
    return r;
  endfunction

  task automatic cycle();
    resp_t       e;
    logic        a1, a3, hold1, hold3, hf1, hf3;
    logic [31:0] hd1, hd3;
    #1;
    chk("fetch_ready1", 32'(fr1), 32'((!rv1 || rr1) && busy_left == 0));
    chk("fetch_ready3", 32'(fr3), 32'((!rv3 || rr3) && busy_left == 0));
    chk("busy1", 32'(busy1), 32'(busy_left != 0));
    chk("busy3", 32'(busy3), 32'(busy_left != 0));
    a1 = req1 && fr1;
    a3 = req3 && fr3;
    if (rv1 && rr1) begin
      if (q1.size() == 0) chk("spurious1", 32'(rv1), 0);
      else begin
        e = q1.pop_front();
        chk("data1", rd1, e.data);
        chk("fault1", 32'(rf1), 32'(e.fault));
      end
    end
    if (rv3 && rr3) begin
      if (q3.size() == 0) chk("spurious3", 32'(rv3), 0);
      else begin
        e = q3.pop_front();
        chk("data3", rd3, e.data);
        chk("fault3", 32'(rf3), 32'(e.fault));
      end
    end
    hold1 = rv1 && !rr1; hd1 = rd1; hf1 = rf1;
    hold3 = rv3 && !rr3; hd3 = rd3; hf3 = rf3;
    if (a1) q1.push_back(model_fetch(fa));
    if (a3) q3.push_back(model_fetch(fa));
    @(posedge clk);
    if (busy_left > 0) begin
      mem_m[DEPTH - busy_left] = '0;
      busy_left--;
    end else if (clr) begin
      busy_left = DEPTH;
    end
    if (ld_en && (ld_addr >> 2) < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
        if (ld_be[b]) mem_m[ld_addr >> 2][b*8 +: 8] = ld_data[b*8 +: 8];
      end
    end
    @(negedge clk);
    if (hold1) begin
      chk("hold_v1", 32'(rv1), 1);
      chk("hold_d1", rd1, hd1);
      chk("hold_f1", 32'(rf1), 32'(hf1));
    end
    if (hold3) begin
      chk("hold_v3", 32'(rv3), 1);
      chk("hold_d3", rd3, hd3);
      chk("hold_f3", 32'(rf3), 32'(hf3));
    end
  endtask

  task automatic idle_inputs();
    req1 = 1'b0; req3 = 1'b0; rr1 = 1'b1; rr3 = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_be = '0; clr = 1'b0; fa = '0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ld_en = 1'b1; ld_addr = a; ld_data = d; ld_be = be;
    cycle();
    ld_en = 1'b0;
  endtask

  task automatic fetch1(input logic [31:0] a, output logic v, output logic [31:0] d, output logic f);
    req1 = 1'b1; fa = a; rr1 = 1'b1;
    cycle();
    req1 = 1'b0;
    v = rv1; d = rd1; f = rf1;
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[8];
    seq_t        s3[8];
    logic        v, f;
    logic [31:0] d;
    int          n;

    checks = 0; errors = 0; busy_left = 0;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_v1", 32'(rv1), 0);   chk("rst_d1", rd1, 0);   chk("rst_f1", 32'(rf1), 0);
    chk("rst_v3", 32'(rv3), 0);   chk("rst_d3", rd3, 0);   chk("rst_busy", 32'(busy1), 0);
    reset_n = 1'b1;

    load(32'h28, 32'h00A0_0613, 4'hF);
    load(32'h00, 32'h1111_1111, 4'hF);
    load(32'h04, 32'h2222_2222, 4'hF);
    load(32'h08, 32'h3333_3333, 4'hF);
    load(32'h3C, 32'hCAFE_F00D, 4'hF);
    load(32'h40, 32'hDEAD_BEEF, 4'hF);

    vt = '{
      '{32'h0000_0028, 32'h00A0_0613, 1'b0},
      '{32'h0000_0002, NOP,           1'b1},
      '{32'h0000_1000, NOP,           1'b1},
      '{32'h0000_0040, NOP,           1'b1},
      '{32'h0000_003C, 32'hCAFE_F00D, 1'b0},
      '{32'h0000_0001, NOP,           1'b1},
      '{32'h0000_0000, 32'h1111_1111, 1'b0},
      '{32'hFFFF_FFFC, NOP,           1'b1}
    };
    for (int i = 0; i < 8; i++) begin
      fetch1(vt[i].addr, v, d, f);
      chk($sformatf("tbl_v[%0d]", i), 32'(v), 1);
      chk($sformatf("tbl_d[%0d]", i), d, vt[i].data);
      chk($sformatf("tbl_f[%0d]", i), 32'(f), 32'(vt[i].fault));
    end

    s3 = '{
      '{1'b1, 32'h0, 1'b1, 1'b0, 32'h0},
      '{1'b1, 32'h4, 1'b1, 1'b0, 32'h0},
      '{1'b1, 32'h8, 1'b1, 1'b1, 32'h1111_1111},
      '{1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_1111},
      '{1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_1111},
      '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2222_2222},
      '{1'b0, 32'h0, 1'b1, 1'b1, 32'h3333_3333},
      '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0}
    };
    for (int i = 0; i < 8; i++) begin
      req3 = s3[i].req; fa = s3[i].addr; rr3 = s3[i].rr;
      cycle();
      chk($sformatf("lat3_v[%0d]", i), 32'(rv3), 32'(s3[i].v));
      if (s3[i].v) chk($sformatf("lat3_d[%0d]", i), rd3, s3[i].d);
    end
    idle_inputs();

    load(32'h10, 32'hFFFF_FFFF, 4'hF);
    ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'h0; ld_be = 4'b0010;
    req1 = 1'b1; fa = 32'h10;
    cycle();
    ld_en = 1'b0; req1 = 1'b0;
    chk("rdfirst_v", 32'(rv1), 1);
    chk("rdfirst_d", rd1, 32'hFFFF_FFFF);
    cycle();
    fetch1(32'h10, v, d, f);
    chk("be_merge", d, 32'hFFFF_00FF);

    clr = 1'b1;
    cycle();
    clr = 1'b0; req1 = 1'b1; req3 = 1'b1; fa = 32'h4; n = 0;
    while (busy1 && n < 40) begin
      n++;
      cycle();
    end
    req1 = 1'b0; req3 = 1'b0;
    chk("clear_len", 32'(n), 16);
    for (int i = 0; i < DEPTH; i++) begin
      fetch1(32'(i) << 2, v, d, f);
      chk($sformatf("cleared[%0d]", i), d, 32'h0);
    end

    for (int c = 0; c < 600; c++) begin
      req1    = 1'($urandom_range(0, 1));
      req3    = 1'($urandom_range(0, 1));
      rr1     = ($urandom_range(0, 3) != 0);
      rr3     = ($urandom_range(0, 3) != 0);
      fa      = ($urandom_range(0, 9) == 0) ? $urandom : (32'($urandom_range(0, 19)) << 2);
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = 32'($urandom_range(0, 79));
      ld_data = $urandom;
      ld_be   = 4'($urandom_range(0, 15));
      clr     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle_inputs();
    repeat (DEPTH + 8) cycle();
    chk("drain1", 32'(q1.size()), 0);
    chk("drain3", 32'(q3.size()), 0);

    load(32'h3C, 32'h5A5A_1234, 4'hF);
    load(32'h00, 32'h7777_7777, 4'hF);
    req1 = 1'b1; fa = 32'h3C; rr1 = 1'b0; clr = 1'b1;
    cycle();
    req1 = 1'b0; clr = 1'b0;
    repeat (10) cycle();
    reset_n = 1'b0;
    #1;
    chk("rstclr_busy", 32'(busy1), 0);
    chk("rstclr_v1", 32'(rv1), 0);
    chk("rstclr_v3", 32'(rv3), 0);
    q1.delete(); q3.delete(); busy_left = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; rr1 = 1'b1;
    fetch1(32'h3C, v, d, f);
    chk("rstclr_w15", d, 32'h5A5A_1234);
    fetch1(32'h00, v, d, f);
    chk("rstclr_w0", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
